// File: rtl/spike_phase_detector.sv
// Spike phase detector: measures the lag in cycles between spikes on two neuron oscillators,
// flags which one led, and asserts lock once the lag has stayed stable for LOCK_COUNT measurements.
module spike_phase_detector #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_TOL   = 1,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             spike_a,
  input  logic             spike_b,
  output logic [CNT_W-1:0] phase,
  output logic             phase_valid,
  output logic             lead_a,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W:0]   TolW    = (CNT_W + 1)'(LOCK_TOL);
  localparam logic [3:0]       LockCnt = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StWaitB, StWaitA} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             lead_q, lead_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] prev_phase_q, prev_phase_d;
  logic             prev_lead_q, prev_lead_d;
  logic             have_prev_q, have_prev_d;

  // Measurement produced on this edge, if any
  logic             meas;
  logic [CNT_W-1:0] meas_phase;
  logic             meas_lead;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   diff;
  logic             stable;
  logic [3:0]       stable_next;

  // Closing on the timeout edge reports the saturated maximum rather than wrapping
  assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;

  always_comb begin
    diff = ({1'b0, meas_phase} >= {1'b0, prev_phase_q}) ?
           ({1'b0, meas_phase} - {1'b0, prev_phase_q}) :
           ({1'b0, prev_phase_q} - {1'b0, meas_phase});
    stable = have_prev_q && (meas_lead == prev_lead_q) && (diff <= TolW);
    if (!stable) begin
      stable_next = 4'd0;
    end else if (stable_q >= LockCnt) begin
      stable_next = LockCnt;
    end else begin
      stable_next = stable_q + 4'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    lead_d       = lead_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;
    locked_d     = locked_q;
    stable_d     = stable_q;
    prev_phase_d = prev_phase_q;
    prev_lead_d  = prev_lead_q;
    have_prev_d  = have_prev_q;
    meas         = 1'b0;
    meas_phase   = '0;
    meas_lead    = 1'b0;

    if (clear) begin
      state_d      = StIdle;
      cnt_d        = '0;
      locked_d     = 1'b0;
      stable_d     = 4'd0;
      prev_phase_d = '0;
      prev_lead_d  = 1'b0;
      have_prev_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (spike_a && spike_b) begin
            meas = 1'b1;
          end else if (spike_a) begin
            state_d = StWaitB;
            cnt_d   = '0;
          end else if (spike_b) begin
            state_d = StWaitA;
            cnt_d   = '0;
          end
        end
        StWaitB: begin
          if (spike_b) begin
            meas       = 1'b1;
            meas_phase = cnt_inc;
            meas_lead  = 1'b1;
            cnt_d      = '0;
            state_d    = spike_a ? StWaitB : StIdle;
          end else if (cnt_q == CntMax) begin
            timeout_d   = 1'b1;
            state_d     = StIdle;
            cnt_d       = '0;
            locked_d    = 1'b0;
            stable_d    = 4'd0;
            have_prev_d = 1'b0;
          end else if (spike_a) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitA: begin
          if (spike_a) begin
            meas       = 1'b1;
            meas_phase = cnt_inc;
            meas_lead  = 1'b0;
            cnt_d      = '0;
            state_d    = spike_b ? StWaitA : StIdle;
          end else if (cnt_q == CntMax) begin
            timeout_d   = 1'b1;
            state_d     = StIdle;
            cnt_d       = '0;
            locked_d    = 1'b0;
            stable_d    = 4'd0;
            have_prev_d = 1'b0;
          end else if (spike_b) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase

      if (meas) begin
        phase_d      = meas_phase;
        lead_d       = meas_lead;
        valid_d      = 1'b1;
        stable_d     = stable_next;
        locked_d     = (stable_next == LockCnt);
        prev_phase_d = meas_phase;
        prev_lead_d  = meas_lead;
        have_prev_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      phase_q      <= '0;
      lead_q       <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      locked_q     <= 1'b0;
      stable_q     <= 4'd0;
      prev_phase_q <= '0;
      prev_lead_q  <= 1'b0;
      have_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      lead_q       <= lead_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      locked_q     <= locked_d;
      stable_q     <= stable_d;
      prev_phase_q <= prev_phase_d;
      prev_lead_q  <= prev_lead_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign lead_a      = lead_q;
  assign timeout     = timeout_q;
  assign locked      = locked_q;

endmodule

// File: doc/spike_phase_detector.md
Name: spike_phase_detector

Overview:
- Sits directly downstream of two neuron oscillators; samples their spike outputs and measures the phase lag, in clock cycles, between a spike on one and the next spike on the other.
- Reports each lag with a one-cycle valid strobe and a lead-direction flag.
- Asserts a lock indicator once the pair has held a stable phase relationship.
- The lock indicator feeds the network coupling/control logic that decides when to re-enable neurons.

Parameters:
- CNT_W, 8, width of the lag counter and of the phase output.
- LOCK_TOL, 1, maximum absolute change in phase between consecutive measurements that still counts as stable.
- LOCK_COUNT, 4, number of consecutive stable measurements required to assert locked (range 1..15).

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear: abort measurement, drop lock.
- spike_a  input  1  spike from neuron A, synchronous to clk; may be high for one or more cycles; every sampled high counts as an event.
- spike_b  input  1  spike from neuron B, same rules as spike_a.
- phase  output  CNT_W  last measured lag in cycles; held between measurements.
- phase_valid  output  1  one-cycle strobe: phase/lead_a just updated.
- lead_a  output  1  1 = A spiked first in last measurement; 0 = B first or simultaneous.
- timeout  output  1  one-cycle strobe: open measurement abandoned.
- locked  output  1  stable phase relationship held.

Behaviour:
- Reset (asynchronous, any time including mid-measurement):
  - state=IDLE, counter=0, phase=0, phase_valid=0, lead_a=0, timeout=0, locked=0.
  - Stable-measurement counter and previous-phase/previous-lead registers are cleared.
- clear=1 at an edge: same effect as reset except phase and lead_a hold their values. clear has priority over spike inputs.
- States: IDLE, WAIT_B (A opened), WAIT_A (B opened). All outputs are registered.
- IDLE:
  - spike_a & !spike_b: go to WAIT_B, counter<=0.
  - spike_b & !spike_a: go to WAIT_A, counter<=0.
  - spike_a & spike_b: immediate measurement with phase<=0, lead_a<=0, phase_valid<=1; stay in IDLE.
- WAIT_B:
  - Each edge without spike_b: counter<=counter+1.
  - spike_b sampled k edges after the opening edge: phase<=k (counter+1), lead_a<=1, phase_valid<=1, go to IDLE.
  - spike_b & spike_a on the same edge: complete the measurement as above, then reopen WAIT_B with counter<=0. The new A spike is not lost.
  - spike_a without spike_b: restart, counter<=0, stay in WAIT_B, no strobe.
- WAIT_A: mirror of WAIT_B with A and B swapped and lead_a<=0.
- Timeout:
  - If the counter equals 2^CNT_W-1 at an edge with no closing spike: timeout<=1, go to IDLE.
  - No phase_valid; phase holds; locked<=0; stable counter<=0.
  - A closing spike on that same edge wins over the timeout.
- Counter never wraps; the maximum reportable phase is 2^CNT_W-1.
- Latency: phase_valid is high in the cycle after the closing edge. Back-to-back strobes are possible.
- Lock evaluation on each measurement, using the new phase p and previous phase q:
  - Stable if lead_a equals the previous lead and |p-q|<=LOCK_TOL, computed in CNT_W+1 bits, unsigned magnitude.
  - Stable: stable counter increments, saturating at LOCK_COUNT.
  - Not stable: stable counter is set to 0.
  - locked<=(stable counter after update == LOCK_COUNT); it updates on the same edge as phase_valid.
  - The first measurement after reset/clear/timeout has no previous value and is never stable.
  - p and lead_a are stored as the previous values on every measurement.

Test Plan:
- Reset mid-WAIT_B (spike_a, 5 idle cycles, assert reset) -> all outputs 0 immediately; after release, spike_b alone opens WAIT_A with no stale phase strobe.
- spike_a at edge T, spike_b at edge T+7 -> phase_valid=1 for exactly one cycle after T+7, phase=7, lead_a=1; spike_b at T, spike_a at T+3 -> phase=3, lead_a=0.
- spike_a and spike_b high on the same edge in IDLE -> phase=0, lead_a=0, phase_valid strobe; in WAIT_B after 4 cycles -> phase=5 strobe, new measurement opened, following spike_b 2 edges later -> phase=2.
- spike_a only, CNT_W=4 -> timeout strobe when the counter reaches 15, no phase_valid, locked drops; spike_b arriving exactly on that edge -> phase=15, no timeout.
- Periodic pairs with lags 6,6,7,6,5 (A leading), LOCK_TOL=1, LOCK_COUNT=4 -> locked rises with the 5th measurement's strobe; next lag 9 -> locked falls; a B-leading measurement also drops lock.
- Repeated spike_a (restart) at +2 and +4, then spike_b at +6 -> phase=2; clear during WAIT_A -> IDLE, locked=0, phase unchanged.
